fifo_reader: RTL

Read-side controller for the team's single-clock FIFO. It drains a programmed number of words from the FIFO read port, absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer, and presents the words downstream on a valid/ready stream. It never reads an empty FIFO and never drops a word under downstream backpressure.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/skid_buf3.sv | 50 +++++
 rtl/fifo_reader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and defaults.
// Used by the FIFO and its read controller.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } state_t;

  localparam int SKID_DEPTH = 3;
  localparam int DATA_WIDTH = 4;
  localparam int CNT_WIDTH  = 8;

  // Advance a skid pointer, wrapping 2 -> 0.
  function automatic logic [1:0] ptr_inc(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/skid_buf3.sv
// 3-entry circular skid buffer.
// Absorbs the FIFO's registered read latency.
module skid_buf3
  import fifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [data_width-1:0] i_din,
  input  logic                  i_pop,
  output logic [data_width-1:0] o_dout,
  output logic [1:0]            o_occ
);

  logic [data_width-1:0] r_mem [SKID_DEPTH];
  logic [1:0]            r_wptr;
  logic [1:0]            r_rptr;
  logic [1:0]            r_occ;

  // Storage, pointers and occupancy; push+pop keeps occ.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (i_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      unique case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_dout = r_mem[r_rptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the single-clock FIFO.
// Drains a burst into a valid/ready stream.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int cnt_width  = CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [cnt_width-1:0]  burst_len,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [data_width-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data,
  output logic                  busy,
  output logic                  done
);

  state_t               r_state;
  state_t               w_next;
  logic [cnt_width-1:0] r_len;
  logic [cnt_width-1:0] r_remaining;
  logic [cnt_width-1:0] r_delivered;
  logic [cnt_width-1:0] w_dlv_nx;
  logic                 r_inflight;
  logic [1:0]           w_occ;
  logic [2:0]           w_fill;
  logic                 w_room;
  logic                 w_xfer;
  logic                 w_re;

  skid_buf3 #(
    .data_width(data_width)
  ) u_skid (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_push (r_inflight),
    .i_din  (fifo_rdata),
    .i_pop  (w_xfer),
    .o_dout (m_data),
    .o_occ  (w_occ)
  );

  assign w_fill   = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_room   = w_fill < 3'(SKID_DEPTH);
  assign m_valid  = (w_occ != 2'd0);
  assign w_xfer   = m_valid && m_ready;
  assign w_dlv_nx = r_delivered + cnt_width'(1);
  assign fifo_re  = w_re;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, read enable and status outputs.
  always_comb begin
    w_next = r_state;
    w_re   = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = (burst_len != '0) ? READ : FINISH;
        end
      end
      READ: begin
        w_re = !fifo_empty && w_room &&
               (r_remaining != '0);
        if (w_re && r_remaining == cnt_width'(1)) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_xfer && w_dlv_nx == r_len) begin
          w_next = FINISH;
        end
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Burst counters and the read-latency tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len       <= '0;
      r_remaining <= '0;
      r_delivered <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_re;
      if (r_state == IDLE) begin
        if (start) begin
          r_len       <= burst_len;
          r_remaining <= burst_len;
          r_delivered <= '0;
        end
      end else begin
        if (w_re) begin
          r_remaining <= r_remaining - cnt_width'(1);
        end
        if (w_xfer) begin
          r_delivered <= w_dlv_nx;
        end
      end
    end
  end

endmodule
